mem_arb: RTL
============

Name: mem_arb

Overview:
- Arbitrates the single unified memory port between the instruction-fetch requester and the load/store (data) requester of the multicycle core.
- Latches the winning request, drives the memory port, and returns read data with a registered one-cycle ack.
- Aborts with an error response when the memory does not ack within a bounded time.
- Sits between main control / fetch unit / LSU and the memory model or bus bridge.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports; byte enables are DATA_W/8 bits.
- TIMEOUT, 16, max cycles m_req may stay asserted without m_ack; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  reset, synchronous, active-high.
- ce  input  1  enables new arbitration in IDLE only.
- f_req  input  1  fetch request, level, held until f_ack.
- f_addr  input  ADDR_W  fetch address (read-only port).
- f_rdata  output  DATA_W  fetch read data, valid with f_ack.
- f_ack  output  1  one-cycle completion pulse.
- f_err  output  1  qualifies f_ack; 1 = timeout.
- d_req  input  1  data request, level, held until d_ack.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  write data.
- d_be  input  DATA_W/8  byte enables.
- d_rdata  output  DATA_W  read data, valid with d_ack on reads.
- d_ack  output  1  one-cycle completion pulse.
- d_err  output  1  qualifies d_ack.
- m_req  output  1  memory request, held until m_ack or timeout.
- m_we  output  1  memory write enable.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  DATA_W  memory write data.
- m_be  output  DATA_W/8  memory byte enables.
- m_rdata  input  DATA_W  memory read data, valid with m_ack.
- m_ack  input  1  memory completion; may be combinational from m_req.

Behaviour:
- Reset values:
  - state = IDLE.
  - m_req, m_we, all acks and errs = 0.
  - m_addr, m_wdata, m_be, f_rdata, d_rdata = 0.
  - last_grant = DATA, so fetch wins the first tie.
  - timeout counter = 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If ce and (f_req or d_req), select a winner.
  - Only one requesting: that one wins.
  - Both requesting: the one not equal to last_grant wins.
  - Register the winner's addr/we/wdata/be onto the m_* registers, set owner and last_grant, clear the counter, go to ISSUE.
  - For fetch, m_we = 0 and m_be = all ones.
  - ce = 0: stay in IDLE with no grant.
- ISSUE:
  - m_req = 1; m_* outputs are stable for the whole state.
  - m_ack = 1: capture m_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), err = 0, go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: err = 1, rdata unchanged, go to RESP.
  - Else increment the counter.
  - ce is ignored in ISSUE and RESP; an in-flight access always completes.
- RESP:
  - m_req = 0; owner's ack = 1 for exactly this cycle, with err as set.
  - Go to IDLE.
- Latency: request visible at edge 0, then ISSUE at cycle 1, RESP (ack) at cycle 2 with a zero-wait memory. Each memory wait cycle adds 1.
- Timeout: m_req is held for exactly TIMEOUT cycles, then RESP with err.
- Requester contract: a requester must deassert req in the cycle after its ack, otherwise it is re-arbitrated as a new request. The arbiter does not enforce this.
- Request dropped while not yet granted: ignored, no ack.
- Inputs changing while owner is in ISSUE: no effect, because m_* are latched.
- Reset mid-operation (ISSUE or RESP): immediately IDLE, m_req = 0, no ack pulse issued.
- Only one of f_ack and d_ack can be high in any cycle.

Decomposition:
- Package mem_arb_pkg: state_t enum {IDLE, ISSUE, RESP} and owner_t enum {OWN_FETCH, OWN_DATA}.
- Sub-module rr_arb2: 2-way round-robin grant from (req_f, req_d, last_grant), combinational, reusable.
- The timeout counter stays inline.

Test Plan:
- Fetch-only read, zero-wait memory returning 0x00000013 at 0x100:
  - f_ack at cycle 2, f_rdata = 0x00000013, f_err = 0.
  - m_we = 0, m_be = 4'hF.
- Data write 0xDEADBEEF to 0x200, be = 4'b0011, memory acks after 3 waits:
  - m_* stable through ISSUE, d_ack at cycle 5, d_rdata unchanged.
- f_req and d_req both high from reset:
  - Fetch granted first, then data.
  - Second tie after both re-request: fetch granted (last_grant = DATA again).
  - Two consecutive ties alternate F, D, F, D.
- Memory never acks, TIMEOUT = 16:
  - m_req high exactly 16 cycles, then d_ack = 1 with d_err = 1.
  - Next request proceeds normally.
- reset asserted during ISSUE:
  - Next cycle m_req = 0, no ack pulse, state IDLE.
  - A new fetch after reset completes in 2 cycles.
- ce = 0 with f_req high: no m_req. Raise ce: grant on the next edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states and access owner.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Single-bit encoding so the owner can travel on plain logic ports.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time gets the port.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic req_f_i,
    input  logic req_d_i,
    input  logic last_grant_i,
    output logic gnt_vld_o,
    output logic gnt_d_o
);

    always_comb begin
        gnt_vld_o = req_f_i | req_d_i;
        gnt_d_o   = 1'b0;
        if (req_f_i && req_d_i) begin
            gnt_d_o = (last_grant_i == logic'(OWN_FETCH));
        end else if (req_d_i) begin
            gnt_d_o = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates the single memory port between instruction fetch and load/store, latching the
// winning request, holding m_req until m_ack or timeout, then pulsing the owner's ack for one cycle.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce,
    input  logic                f_req,
    input  logic [ADDR_W-1:0]   f_addr,
    output logic [DATA_W-1:0]   f_rdata,
    output logic                f_ack,
    output logic                f_err,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                d_err,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_ack
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t              state_q, state_d;
    owner_t              owner_q, last_grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                m_we_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [BE_W-1:0]     m_be_q;
    logic [DATA_W-1:0]   f_rdata_q, d_rdata_q;

    logic                gnt_vld, gnt_d;
    logic                start;
    logic                timeout_hit;
    owner_t              gnt_owner;

    rr_arb2 u_rr_arb2 (
        .req_f_i      (f_req),
        .req_d_i      (d_req),
        .last_grant_i (logic'(last_grant_q)),
        .gnt_vld_o    (gnt_vld),
        .gnt_d_o      (gnt_d)
    );

    assign gnt_owner   = owner_t'(gnt_d);
    assign start       = ce && gnt_vld;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (m_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, timeout counter and read-data capture; m_* stay frozen while in ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= OWN_FETCH;
            last_grant_q <= OWN_DATA;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        owner_q      <= gnt_owner;
                        last_grant_q <= gnt_owner;
                        cnt_q        <= '0;
                        if (gnt_owner == OWN_FETCH) begin
                            m_we_q    <= 1'b0;
                            m_addr_q  <= f_addr;
                            m_wdata_q <= '0;
                            m_be_q    <= '1;
                        end else begin
                            m_we_q    <= d_we;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                            m_be_q    <= d_be;
                        end
                    end
                end
                ISSUE: begin
                    if (m_ack) begin
                        err_q <= 1'b0;
                        if (!m_we_q) begin
                            if (owner_q == OWN_FETCH) f_rdata_q <= m_rdata;
                            else                      d_rdata_q <= m_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m_req   = (state_q == ISSUE);
        f_ack   = (state_q == RESP) && (owner_q == OWN_FETCH);
        d_ack   = (state_q == RESP) && (owner_q == OWN_DATA);
        f_err   = f_ack && err_q;
        d_err   = d_ack && err_q;
        m_we    = m_we_q;
        m_addr  = m_addr_q;
        m_wdata = m_wdata_q;
        m_be    = m_be_q;
        f_rdata = f_rdata_q;
        d_rdata = d_rdata_q;
    end

endmodule
